// File: rtl/unified_mem_pkg.sv
// unified_mem_pkg: shared FSM encoding, default geometry and a clog2 helper for the unified memory.
package unified_mem_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int DEF_LINE_W     = 256;
    localparam int DEF_WORD_W     = 64;
    localparam int DEF_DEPTH      = 4096;
    localparam int WORDS_PER_LINE = DEF_LINE_W / DEF_WORD_W;
    localparam int LINE_OFF_BITS  = clog2(DEF_LINE_W / 8);
    localparam int WORD_OFF_BITS  = clog2(DEF_WORD_W / 8);
    localparam int IDX_BITS       = clog2(DEF_DEPTH);

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr_i (wrapping).
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o
);

    // Walking offsets downwards lets the closest requester overwrite farther ones.
    always_comb begin
        int idx;
        idx   = 0;
        gnt_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr_i) + i) % N;
            if (req_i[idx]) gnt_o = N'(1) << idx;
        end
    end

endmodule

// File: rtl/unified_main_mem.sv
// unified_main_mem: shared backing memory with round-robin arbitration over line-read and word-write channels.
// Optional UNIFIED_MEM_RANGE_CHECK_EN adds o_rd_err/o_wr_err and flags out-of-range word indices.
module unified_main_mem
    import unified_mem_pkg::*;
#(
    parameter int NUM_RD_CH   = 2,
    parameter int ADDR_W      = 64,
    parameter int LINE_W      = DEF_LINE_W,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int DEPTH_WORDS = DEF_DEPTH,
    parameter int RD_LAT      = 4,
    parameter int WR_LAT      = 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NUM_RD_CH-1:0]        i_rd_req,
    input  logic [NUM_RD_CH*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD_CH-1:0]        o_rd_done,
    output logic [LINE_W-1:0]           o_rd_line,
    input  logic                        i_wr_valid,
    input  logic [ADDR_W-1:0]           i_wr_addr,
    input  logic [WORD_W-1:0]           i_wr_data,
    input  logic [WORD_W/8-1:0]         i_wr_strb,
    output logic                        o_wr_done
`ifdef UNIFIED_MEM_RANGE_CHECK_EN
    ,
    output logic [NUM_RD_CH-1:0]        o_rd_err,
    output logic                        o_wr_err
`endif
);

    localparam int NREQ = NUM_RD_CH + 1;
    localparam int WPL  = LINE_W / WORD_W;
    localparam int WOFF = clog2(WORD_W / 8);
    localparam int IDXW = clog2(DEPTH_WORDS);
    localparam int PTRW = clog2(NREQ);
    localparam int CNTW = clog2(RD_LAT > WR_LAT ? RD_LAT : WR_LAT) + 1;

    state_e               state_q, state_d;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic [PTRW-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, gnt_idx;
    logic [IDXW-1:0]      widx_q, widx_d, line_base;
    logic [WORD_W-1:0]    data_q, data_d;
    logic [WORD_W/8-1:0]  strb_q, strb_d;
    logic                 oob_q, oob_d, oob_sel;
    logic [LINE_W-1:0]    line_q;
    logic [NREQ-1:0]      req, gnt_oh;
    logic [ADDR_W-1:0]    sel_addr;
    logic                 access, is_wr, unused_ok;
    logic [WORD_W-1:0]    mem [DEPTH_WORDS];

    assign req = {i_wr_valid, i_rd_req};

    rr_arbiter #(.N(NREQ), .PW(PTRW)) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (gnt_oh)
    );

    always_comb begin
        gnt_idx  = '0;
        sel_addr = i_wr_addr;
        for (int k = 0; k < NREQ; k++) if (gnt_oh[k]) gnt_idx = PTRW'(k);
        for (int k = 0; k < NUM_RD_CH; k++) if (gnt_oh[k]) sel_addr = i_rd_addr[k*ADDR_W +: ADDR_W];
    end

`ifdef UNIFIED_MEM_RANGE_CHECK_EN
    assign oob_sel   = |sel_addr[ADDR_W-1:WOFF+IDXW];
    assign unused_ok = ^sel_addr[WOFF-1:0];
`else
    assign oob_sel   = 1'b0;
    assign unused_ok = ^{sel_addr[WOFF-1:0], sel_addr[ADDR_W-1:WOFF+IDXW]};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        widx_d  = widx_q;
        data_d  = data_q;
        strb_d  = strb_q;
        oob_d   = oob_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = BUSY;
                gnt_d   = gnt_idx;
                widx_d  = sel_addr[WOFF +: IDXW];
                data_d  = i_wr_data;
                strb_d  = i_wr_strb;
                oob_d   = oob_sel;
                cnt_d   = gnt_oh[NUM_RD_CH] ? CNTW'(WR_LAT - 1) : CNTW'(RD_LAT - 1);
            end
            BUSY: begin
                cnt_d   = cnt_q - CNTW'(1);
                state_d = cnt_q == '0 ? DONE : BUSY;
            end
            DONE: begin
                state_d = IDLE;
                ptr_d   = gnt_q == PTRW'(NUM_RD_CH) ? '0 : gnt_q + PTRW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            widx_q  <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            oob_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            widx_q  <= widx_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
            oob_q   <= oob_d;
        end
    end

    assign is_wr     = gnt_q == PTRW'(NUM_RD_CH);
    assign access    = state_q == BUSY && cnt_q == '0;
    assign line_base = widx_q & ~IDXW'(WPL - 1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) line_q <= '0;
        else if (access && !is_wr)
            for (int i = 0; i < WPL; i++) line_q[i*WORD_W +: WORD_W] <= oob_q ? '0 : mem[line_base | IDXW'(i)];
    end

    // Storage is deliberately left out of reset; async reset clears state_q so an aborted write never lands.
    always_ff @(posedge i_clk) begin
        if (access && is_wr && !oob_q)
            for (int b = 0; b < WORD_W / 8; b++) if (strb_q[b]) mem[widx_q][b*8 +: 8] <= data_q[b*8 +: 8];
    end

    assign o_rd_line = line_q;
    assign o_rd_done = (state_q == DONE && !is_wr) ? NUM_RD_CH'(1) << gnt_q : '0;
    assign o_wr_done = state_q == DONE && is_wr;
`ifdef UNIFIED_MEM_RANGE_CHECK_EN
    assign o_rd_err  = oob_q ? o_rd_done : '0;
    assign o_wr_err  = o_wr_done && oob_q;
`endif

endmodule

// File: tb/tb_unified_main_mem.sv
// tb_unified_main_mem: random and directed traffic against a cycle-budget reference of the shared memory.
module tb_unified_main_mem;

    localparam int N   = 2;
    localparam int AW  = 64;
    localparam int LW  = 256;
    localparam int WW  = 64;
    localparam int DEP = 4096;
    localparam int RL  = 4;
    localparam int WL  = 2;
    localparam int WPL = LW / WW;

    logic            clk = 1'b0;
    logic            i_rst_n;
    logic [N-1:0]    i_rd_req;
    logic [N*AW-1:0] i_rd_addr;
    logic [N-1:0]    o_rd_done;
    logic [LW-1:0]   o_rd_line;
    logic            i_wr_valid;
    logic [AW-1:0]   i_wr_addr;
    logic [WW-1:0]   i_wr_data;
    logic [WW/8-1:0] i_wr_strb;
    logic            o_wr_done;
`ifdef UNIFIED_MEM_RANGE_CHECK_EN
    logic [N-1:0]    o_rd_err;
    logic            o_wr_err;
`endif

    always #5 clk = ~clk;

    unified_main_mem #(
        .NUM_RD_CH(N), .ADDR_W(AW), .LINE_W(LW), .WORD_W(WW),
        .DEPTH_WORDS(DEP), .RD_LAT(RL), .WR_LAT(WL)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .o_rd_done(o_rd_done), .o_rd_line(o_rd_line),
        .i_wr_valid(i_wr_valid), .i_wr_addr(i_wr_addr),
        .i_wr_data(i_wr_data), .i_wr_strb(i_wr_strb),
        .o_wr_done(o_wr_done)
`ifdef UNIFIED_MEM_RANGE_CHECK_EN
        , .o_rd_err(o_rd_err), .o_wr_err(o_wr_err)
`endif
    );

    int            n_cmp = 0, n_err = 0;
    int            cyc = 0, done_at = -1, free_at = 0, cur = 0, ptr = 0, pw_idx = 0;
    int            ndone [N+1];
    logic [N:0]    pend;
    logic [AW-1:0] ra [N];
    logic [AW-1:0] wa;
    logic [WW-1:0] wd, pw_data;
    logic [7:0]    ws, pw_strb;
    logic [LW-1:0] exp_line, nxt_line;
    logic          nxt_err;
    logic [WW-1:0] mm [DEP];

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 511));
`ifndef UNIFIED_MEM_RANGE_CHECK_EN
        a = a | (AW'($urandom_range(0, 7)) << 15) | (AW'($urandom) << 32);
`endif
        return a;
    endfunction

    task automatic drive();
        i_rd_req   = pend[N-1:0];
        i_wr_valid = pend[N];
        for (int k = 0; k < N; k++) i_rd_addr[k*AW +: AW] = ra[k];
        i_wr_addr  = wa;
        i_wr_data  = wd;
        i_wr_strb  = ws;
    endtask

    // mode 0: hold stimulus, 1: random traffic, 2: ch0/ch1 re-request immediately after done
    task automatic step(input int mode);
        logic [N-1:0]  ed;
        logic          ew, oob, found;
        logic [AW-1:0] a;
        int            widx, base, lat;
        @(negedge clk);
        cyc++;
        ed = '0;
        if (cyc == done_at && cur < N) begin
            ed[cur]  = 1'b1;
            exp_line = nxt_line;
        end
        ew = cyc == done_at && cur == N;
        chk("rd_done", LW'(o_rd_done), LW'(ed));
        chk("wr_done", LW'(o_wr_done), LW'(ew));
        chk("rd_line", o_rd_line, exp_line);
`ifdef UNIFIED_MEM_RANGE_CHECK_EN
        chk("rd_err", LW'(o_rd_err), LW'(nxt_err ? ed : '0));
        chk("wr_err", LW'(o_wr_err), LW'(ew && nxt_err));
`endif
        if (cyc == done_at) begin
            if (cur == N && !nxt_err)
                for (int b = 0; b < 8; b++) if (pw_strb[b]) mm[pw_idx][b*8 +: 8] = pw_data[b*8 +: 8];
            pend[cur] = 1'b0;
            ptr = (cur + 1) % (N + 1);
            ndone[cur]++;
            if (mode == 2 && cur < 2) pend[cur] = 1'b1;
        end
        if (mode == 1)
            for (int k = 0; k <= N; k++) if (!pend[k] && $urandom_range(0, 3) == 0) pend[k] = 1'b1;
        if (mode != 0) begin
            for (int k = 0; k < N; k++) ra[k] = rnd_addr();
            wa = rnd_addr();
            wd = {$urandom, $urandom};
            ws = 8'($urandom);
        end
        drive();
        if (cyc >= free_at && pend != '0) begin
            found = 1'b0;
            for (int i = 0; i <= N; i++)
                if (!found && pend[(ptr + i) % (N + 1)]) begin
                    found = 1'b1;
                    cur   = (ptr + i) % (N + 1);
                end
            a    = cur < N ? ra[cur] : wa;
            widx = int'((a >> 3) % DEP);
`ifdef UNIFIED_MEM_RANGE_CHECK_EN
            oob  = (a >> 3) >= AW'(DEP);
`else
            oob  = 1'b0;
`endif
            nxt_err = oob;
            if (cur < N) begin
                base = widx - widx % WPL;
                for (int i = 0; i < WPL; i++) nxt_line[i*WW +: WW] = oob ? '0 : mm[base + i];
                lat = RL;
            end else begin
                pw_idx  = widx;
                pw_data = wd;
                pw_strb = ws;
                lat     = WL;
            end
            done_at = cyc + lat + 1;
            free_at = done_at + 1;
        end
    endtask

    task automatic xact(input int k, input logic [AW-1:0] a, input logic [WW-1:0] d, input logic [7:0] s);
        int n0;
        if (k < N) ra[k] = a;
        else begin
            wa = a;
            wd = d;
            ws = s;
        end
        pend[k] = 1'b1;
        n0 = ndone[k];
        for (int t = 0; t < 40 && ndone[k] == n0; t++) step(0);
        chk("xact_done", LW'(ndone[k] - n0), LW'(1));
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && (pend != '0 || cyc < free_at); t++) step(0);
        chk("drain", LW'(pend), '0);
    endtask

    initial begin
        int c0, c1;
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int d0, d1;
        pend = '0;
        for (int k = 0; k <= N; k++) ndone[k] = 0;
        for (int k = 0; k < N; k++) ra[k] = '0;
        wa = '0; wd = '0; ws = '0;
        exp_line = '0; nxt_line = '0; nxt_err = 1'b0; pw_data = '0; pw_strb = '0;
        i_rst_n = 1'b0;
        drive();
        repeat (3) @(negedge clk);
        i_rst_n = 1'b1;

        for (int w = 0; w < 64; w++) xact(N, AW'(w * 8), {$urandom, $urandom}, 8'hFF);

        xact(0, 'h40, '0, '0);
        xact(N, 'h20, 64'hDEADBEEF_CAFEF00D, 8'h0F);
        xact(1, 'h20, '0, '0);

        repeat (400) step(1);
        drain();

        wa = 'h100; wd = {$urandom, $urandom}; ws = 8'hFF;
        pend[N] = 1'b1;
        step(0);
        @(negedge clk);
        i_rst_n = 1'b0;
        pend = '0;
        drive();
        #1;
        chk("rst_wr_done", LW'(o_wr_done), '0);
        chk("rst_rd_done", LW'(o_rd_done), '0);
        chk("rst_rd_line", o_rd_line, '0);
        @(negedge clk);
        i_rst_n = 1'b1;
        cyc += 2;
        done_at = -1; free_at = 0; ptr = 0; exp_line = '0; nxt_err = 1'b0;

        ra[0] = 'h60; ra[1] = 'h1A0; wa = 'h180; wd = {$urandom, $urandom}; ws = 8'h3C;
        pend = '1;
        drain();
        xact(1, 'h100, '0, '0);

        d0 = ndone[0]; d1 = ndone[1];
        pend[0] = 1'b1; pend[1] = 1'b1;
        repeat (60) step(2);
        drain();
        d0 = ndone[0] - d0; d1 = ndone[1] - d1;
        chk("alt_fair", LW'(d0 > 3 && d0 - d1 <= 1 && d1 - d0 <= 1), LW'(1));

        xact(0, 'h8000, '0, '0);

        repeat (3) step(0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
